key_voice_scheduler: RTL
========================

KEY_VOICE_SCHEDULER -- requirements
Module: key_voice_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive clocks a synchronized switch level must hold before it is accepted; legal range 2..65535.
REQ-002 Parameter RELEASE_CYCLES, default 8: number of clocks a voice keeps its note enabled after key release; legal range 1..65535.
REQ-003 Port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port sw, input, 3: raw, asynchronous piano key switches; bit k requests note k.
REQ-006 Port lfsr_en, output, 3: enable to LFSR tone generator k; it drives LFSR1_EN..LFSR3_EN.
REQ-007 Port voice_busy, output, 2: bit v is 1 while voice v is in PLAY or RELEASE.
REQ-008 Port voice_note, output, 2x2: note index (0..2) owned by each voice; 0 when that voice is IDLE.
REQ-009 Port pending, output, 3: debounced key presses waiting for a free voice.

Function
REQ-010 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Per key debounce: counter clears when sync == stable, increments otherwise; when counter == DEBOUNCE_CYCLES-1 and sync != stable, stable <= sync and counter clears; counter width is 16 bits, no wrap.
REQ-012 Press event = stable rising edge; release event = stable falling edge (both single-cycle, from registered stable vs stable_d).
REQ-013 Press on a key not owned by any voice SHALL set pending[k] on the next edge; press on an owned key SHALL NOT set pending.
REQ-014 pending[k] SHALL clear on allocation, or on release of key k before allocation; release and allocation in the same cycle -> cleared, no allocation.
REQ-015 Two voices, each an FSM: IDLE, PLAY, RELEASE.
REQ-016 Allocation: each cycle, the lowest-index pending key goes to the lowest-index IDLE voice, the next pending key to the next IDLE voice; both voices can be allocated in one cycle; the allocated voice enters PLAY on that edge.
REQ-017 PLAY -> RELEASE when stable[note] == 0; release counter loads 0.
REQ-018 RELEASE -> IDLE when the release counter == RELEASE_CYCLES-1; otherwise increment.
REQ-019 RELEASE -> PLAY if stable[note] returns to 1 (re-press retakes the same voice; no pending set).
REQ-020 A voice in RELEASE SHALL NOT be stolen; pending keys wait for IDLE.
REQ-021 lfsr_en[k] = 1 iff some voice is in PLAY or RELEASE with voice_note == k; decoded from registered state only; never glitches between edges.
REQ-022 A clean sw[k] rise with all voices IDLE SHALL raise lfsr_en[k] exactly DEBOUNCE_CYCLES+4 edges later.
REQ-023 No key is ever owned by both voices.

Reset
REQ-024 While rst_n = 0, all of the following SHALL be 0 immediately, independent of clk: synchronizers, stable, counters, pending, voice states (IDLE), voice_note, lfsr_en, voice_busy.
REQ-025 Reset asserted mid-note SHALL drop lfsr_en at once; after deassertion a still-held key SHALL be treated as a new press and re-debounced.

Structure
REQ-026 Shared package key_sched_pkg SHALL hold the voice state enumeration (IDLE, PLAY, RELEASE), NUM_KEYS = 3, NUM_VOICES = 2 and the note index width.
REQ-027 One sub-module, key_debounce (synchronizer + debounce + edge detect for one key), SHALL be instantiated NUM_KEYS times; voice FSMs and allocator stay in the top.

Verification (DEBOUNCE_CYCLES=4, RELEASE_CYCLES=3)
REQ-028 sw=001 held -> lfsr_en=001 after 8 edges, voice_busy=01, voice_note[0]=0; sw=000 -> lfsr_en stays 001 for 3 cycles after PLAY->RELEASE, then 000.
REQ-029 Bounce: sw[1] toggles every 2 cycles for 20 cycles, then 0 -> lfsr_en stays 000, pending stays 000.
REQ-030 sw=111 same cycle -> voice0 note 0, voice1 note 1, pending=100; release key 0 -> after RELEASE expires, key 2 takes voice0, lfsr_en=110.
REQ-031 Key 0 released, re-pressed within RELEASE window -> voice0 returns to PLAY, lfsr_en[0] never drops, voice1 stays IDLE.
REQ-032 rst_n pulled low with lfsr_en=011 -> outputs 0 the same cycle; rst_n high with sw=011 held -> lfsr_en=011 after 8 edges.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types and sizes for the key-to-voice scheduler.
package key_sched_pkg;
  localparam int NUM_KEYS   = 3;
  localparam int NUM_VOICES = 2;
  localparam int NOTE_W     = 2;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } voice_state_t;
endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, hold-time debounce, and press/release edge pulses.
module key_debounce
  import key_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic stable,
  output logic press,
  output logic rel
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], sw};
      stable_d <= stable;
      if (sync_q[1] == stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = stable & ~stable_d;
  assign rel   = ~stable & stable_d;
endmodule

// File: rtl/key_voice_scheduler.sv
// Debounced 3-key front end feeding a 2-voice allocator; each voice holds its
// note through a release tail before it can be reused.
module key_voice_scheduler
  import key_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RELEASE_CYCLES  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_KEYS-1:0]                    sw,
  output logic [NUM_KEYS-1:0]                    lfsr_en,
  output logic [NUM_VOICES-1:0]                  voice_busy,
  output logic [NUM_VOICES-1:0][NOTE_W-1:0]      voice_note,
  output logic [NUM_KEYS-1:0]                    pending
);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

  logic [NUM_KEYS-1:0] stable, press, rel;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_KEYS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .stable (stable),
    .press  (press),
    .rel    (rel)
  );

  voice_state_t                        state_q [NUM_VOICES];
  voice_state_t                        state_d [NUM_VOICES];
  logic [NUM_VOICES-1:0][NOTE_W-1:0]   note_q, note_d;
  logic [NUM_VOICES-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]                 pending_d, owned, avail, alloc_mask;
  logic [NUM_VOICES-1:0]               alloc_vld;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]   alloc_key;

  // Ownership and tone enables come straight from registered voice state.
  always_comb begin
    owned      = '0;
    voice_busy = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (state_q[v] != IDLE) begin
        voice_busy[v]    = 1'b1;
        owned[note_q[v]] = 1'b1;
      end
    end
  end

  assign lfsr_en    = owned;
  assign voice_note = note_q;

  // A release in the same cycle withdraws the key before it can be granted.
  always_comb begin
    avail      = pending & ~rel;
    alloc_mask = '0;
    alloc_vld  = '0;
    alloc_key  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (state_q[v] == IDLE) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (!alloc_vld[v] && avail[k]) begin
            alloc_vld[v]  = 1'b1;
            alloc_key[v]  = NOTE_W'(k);
            avail[k]      = 1'b0;
            alloc_mask[k] = 1'b1;
          end
        end
      end
    end
  end

  assign pending_d = (pending | (press & ~owned)) & ~rel & ~alloc_mask;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      note_d[v]  = note_q[v];
      cnt_d[v]   = cnt_q[v];
      case (state_q[v])
        IDLE: begin
          if (alloc_vld[v]) begin
            state_d[v] = PLAY;
            note_d[v]  = alloc_key[v];
          end
        end
        PLAY: begin
          if (!stable[note_q[v]]) begin
            state_d[v] = RELEASE;
            cnt_d[v]   = '0;
          end
        end
        RELEASE: begin
          // Re-press retakes this voice; the tail is never stolen by others.
          if (stable[note_q[v]]) begin
            state_d[v] = PLAY;
          end else if (cnt_q[v] == REL_LAST) begin
            state_d[v] = IDLE;
            note_d[v]  = '0;
            cnt_d[v]   = '0;
          end else begin
            cnt_d[v] = cnt_q[v] + CNT_W'(1);
          end
        end
        default: begin
          state_d[v] = IDLE;
          note_d[v]  = '0;
          cnt_d[v]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) state_q[v] <= IDLE;
      note_q  <= '0;
      cnt_q   <= '0;
      pending <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) state_q[v] <= state_d[v];
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      pending <= pending_d;
    end
  end
endmodule
